// File: rtl/mcpu_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Handles MULT/MULTU/DIV/DIVU in WIDTH+2 cycles; MTHI/MTLO in one; MFHI/MFLO via o_result.
module mcpu_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic [CW-1:0]    count;
  logic             neg_res;
  logic             neg_rem;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Command decode for the IDLE launch
  logic is_mul, is_div, is_mt, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul    = (i_funct == F_MULT) || (i_funct == F_MULTU);
  assign is_div    = (i_funct == F_DIV) || (i_funct == F_DIVU);
  assign is_mt     = (i_funct == F_MTHI) || (i_funct == F_MTLO);
  assign is_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
  assign a_neg     = is_signed && i_a[WIDTH-1];
  assign b_neg     = is_signed && i_b[WIDTH-1];
  assign a_mag     = a_neg ? (WIDTH'(0) - i_a) : i_a;
  assign b_mag     = b_neg ? (WIDTH'(0) - i_b) : i_b;

  // Shift-add multiply step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_nxt;

  assign mul_add = acc[0] ? opnd : '0;
  assign mul_sum = {1'b0, acc[AW-1:WIDTH]} + {1'b0, mul_add};
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}
  logic [WIDTH+1:0] div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] rem_nxt;
  logic [AW-1:0]    div_nxt;

  assign div_trial = {1'b0, acc[AW-1:WIDTH], acc[WIDTH-1]} - {2'b00, opnd};
  assign div_ok    = ~div_trial[WIDTH+1];
  assign rem_nxt   = div_ok ? div_trial[WIDTH-1:0] : {acc[AW-2:WIDTH], acc[WIDTH-1]};
  assign div_nxt   = {rem_nxt, acc[WIDTH-2:0], div_ok};

  // Sign fix-up of the finished magnitudes
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign prod_fix = neg_res ? (AW'(0) - acc) : acc;
  assign quo_fix  = neg_res ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? (WIDTH'(0) - acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];

  logic fix_is_div;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (is_mul)      state_nxt = S_MUL;
          else if (is_div) state_nxt = S_DIV;
          else if (is_mt)  state_nxt = S_DONE;
        end
      end
      S_MUL, S_DIV: if (count == '0) state_nxt = S_FIX;
      S_FIX:        state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Datapath and HI/LO; fix_is_div remembers which engine ran through FIX
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc        <= '0;
      opnd       <= '0;
      a_raw      <= '0;
      count      <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dbz        <= 1'b0;
      fix_is_div <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && (is_mul || is_div)) begin
            acc        <= {WIDTH'(0), (is_mul ? b_mag : a_mag)};
            opnd       <= is_mul ? a_mag : b_mag;
            a_raw      <= i_a;
            count      <= CW'(WIDTH - 1);
            neg_res    <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
            dbz        <= is_div && (i_b == '0);
            fix_is_div <= is_div;
          end else if (i_start && (i_funct == F_MTHI)) begin
            hi  <= i_a;
            dbz <= 1'b0;
          end else if (i_start && (i_funct == F_MTLO)) begin
            lo  <= i_a;
            dbz <= 1'b0;
          end
        end
        S_MUL: begin
          acc   <= mul_nxt;
          count <= count - CW'(1);
        end
        S_DIV: begin
          acc   <= div_nxt;
          count <= count - CW'(1);
        end
        S_FIX: begin
          if (!fix_is_div) begin
            hi <= prod_fix[AW-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dbz) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_busy        <= (state_nxt != S_IDLE);
      o_done        <= (state_nxt == S_DONE);
      o_div_by_zero <= (state == S_FIX) && fix_is_div && dbz;
    end
  end

  assign o_hi     = hi;
  assign o_lo     = lo;
  assign o_result = (i_funct == F_MFHI) ? hi :
                    (i_funct == F_MFLO) ? lo : '0;

endmodule

// File: tb/tb_mcpu_muldiv_unit.sv
// Randomized bench for mcpu_muldiv_unit against an arithmetic reference model.
module tb_mcpu_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo, result;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mcpu_muldiv_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_funct(funct),
    .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
    .o_div_by_zero(div_by_zero), .o_hi(hi), .o_lo(lo), .o_result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: {div_by_zero, HI, LO} from plain arithmetic
  function automatic logic [64:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f)
      F_MULT:  begin p = sx * sy; return {1'b0, p[63:0]}; end
      F_MULTU: begin up = {32'b0, x} * {32'b0, y}; return {1'b0, up}; end
      F_DIV: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
      F_DIVU: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      F_MTHI:  return {1'b0, x, m_lo};
      F_MTLO:  return {1'b0, m_hi, x};
      default: return {1'b0, m_hi, m_lo};
    endcase
  endfunction

  function automatic logic [31:0] res_of(input logic [5:0] f, input logic [31:0] h, input logic [31:0] l);
    return (f == F_MFHI) ? h : (f == F_MFLO) ? l : 32'h0;
  endfunction

  // Issue one command and check every cycle until the done pulse has gone
  task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit inject);
    logic [64:0] e;
    int lat;
    bit seen;
    e = model(f, x, y);
    lat = (f == F_MTHI || f == F_MTLO) ? 1 : 34;
    seen = 0;
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      #1;
      start = (inject && n == 5);
      funct = 6'($urandom_range(16, 27));
      a = $urandom;
      b = $urandom;
      if (inject && n == 5) funct = F_MTHI;
      #1;
      if (done) begin
        chk("latency", 65'(n), 65'(lat));
        chk("busy_in_done", 65'(busy), 65'(1));
        chk("hi", 65'(hi), 65'(e[63:32]));
        chk("lo", 65'(lo), 65'(e[31:0]));
        chk("div_by_zero", 65'(div_by_zero), 65'(e[64]));
        chk("result_done", 65'(result), 65'(res_of(funct, e[63:32], e[31:0])));
        m_hi = e[63:32];
        m_lo = e[31:0];
        seen = 1;
        break;
      end
      chk("busy_running", 65'(busy), 65'(1));
      chk("hi_stable", 65'(hi), 65'(m_hi));
      chk("lo_stable", 65'(lo), 65'(m_lo));
      chk("dbz_idle", 65'(div_by_zero), 65'(0));
      chk("result_running", 65'(result), 65'(res_of(funct, m_hi, m_lo)));
      @(posedge clk);
    end
    if (!seen) chk("done_timeout", 65'(0), 65'(1));
    start = 1'b0;
    @(posedge clk);
    #2;
    chk("done_single_cycle", 65'(done), 65'(0));
    chk("busy_after", 65'(busy), 65'(0));
    chk("dbz_after", 65'(div_by_zero), 65'(0));
  endtask

  task automatic ignored_cmd(input logic [5:0] f);
    @(negedge clk);
    start = 1'b1; funct = f; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("noop_busy", 65'(busy), 65'(0));
      chk("noop_done", 65'(done), 65'(0));
      chk("noop_hi", 65'(hi), 65'(m_hi));
      chk("noop_lo", 65'(lo), 65'(m_lo));
      @(posedge clk);
    end
  endtask

  task automatic check_result(input logic [5:0] f, input logic [31:0] exp);
    @(negedge clk);
    funct = f;
    #1;
    chk("result_sel", 65'(result), 65'(exp));
  endtask

  logic [31:0] corner [6];
  logic [5:0]  fsel [6];

  initial begin
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    fsel   = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    rst_n = 1'b0; start = 1'b0; funct = '0; a = '0; b = '0;

    // Pin the reference model with hand-computed values
    chk("model_mult", model(F_MULT, 32'd7, 32'hFFFF_FFFD), {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
    chk("model_multu", model(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
    chk("model_div", model(F_DIV, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    chk("model_divu", model(F_DIVU, 32'd100, 32'd7), {1'b0, 64'h0000_0002_0000_000E});
    chk("model_wrap", model(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});

    #12;
    chk("rst_busy", 65'(busy), 65'(0));
    chk("rst_done", 65'(done), 65'(0));
    chk("rst_dbz", 65'(div_by_zero), 65'(0));
    chk("rst_hi", 65'(hi), 65'(0));
    chk("rst_lo", 65'(lo), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op(F_MULT, 32'd7, 32'hFFFF_FFFD, 0);
    chk("lit_mult_hi", 65'(hi), 65'(32'hFFFF_FFFF));
    chk("lit_mult_lo", 65'(lo), 65'(32'hFFFF_FFEB));
    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_result(F_MFLO, 32'h0000_0001);
    check_result(F_MFHI, 32'hFFFF_FFFE);
    check_result(F_MULT, 32'h0);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    chk("lit_div_lo", 65'(lo), 65'(32'hFFFF_FFFD));
    chk("lit_div_hi", 65'(hi), 65'(32'hFFFF_FFFF));
    do_op(F_DIVU, 32'd100, 32'd7, 0);
    chk("lit_divu_lo", 65'(lo), 65'(32'd14));
    chk("lit_divu_hi", 65'(hi), 65'(32'd2));
    do_op(F_DIVU, 32'h1234, 32'h0, 0);
    chk("lit_dbz_lo", 65'(lo), 65'(32'hFFFF_FFFF));
    chk("lit_dbz_hi", 65'(hi), 65'(32'h1234));
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'h0, 0);
    do_op(F_MTHI, 32'hA5A5_A5A5, 32'h0, 0);
    chk("lit_mthi", 65'(hi), 65'(32'hA5A5_A5A5));
    do_op(F_MTLO, 32'h5A5A_0001, 32'h0, 0);
    do_op(F_MULT, 32'h1234_5678, 32'h8765_4321, 1);
    ignored_cmd(F_MFHI);
    ignored_cmd(6'h20);

    // Reset ten edges into a DIV: nothing completes, HI/LO cleared
    @(negedge clk);
    start = 1'b1; funct = F_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 65'(busy), 65'(0));
    chk("arst_done", 65'(done), 65'(0));
    chk("arst_hi", 65'(hi), 65'(0));
    chk("arst_lo", 65'(lo), 65'(0));
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) chk("arst_stray_done", 65'(done), 65'(0));
    end
    do_op(F_MULT, 32'hFFFF_FF00, 32'h0000_0100, 0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  f;
      logic [31:0] x, y;
      f = fsel[$urandom_range(0, 5)];
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = '0;
      do_op(f, x, y, $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
